load_store_buffer: RTL and testbench

In-order load/store queue that sits between dispatch and the memory-side `Cache`. It is the initiator of the cache's data-request handshake (`data_valid`/`data_ready`). Entries capture operands from dispatch and snoop the common data bus (CDB) until their operands are ready. The head entry is then issued to the cache: loads as soon as operands are ready, stores only when they are the ROB head. Completions are reported back to the ROB/CDB.

---
 rtl/lsb_pkg.sv | 52 +++++
 rtl/lsb_ptr_ctrl.sv | 66 ++++++
 rtl/load_store_buffer.sv | 243 ++++++++++++++++++++++++
 tb/tb_load_store_buffer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsb_pkg.sv
// Shared types for the load/store buffer: queue entry record, access size
// encoding, FSM states and the CDB snoop helper.
package lsb_pkg;

    // Storage width for ROB tags inside an entry; ROB_W of the buffer must not exceed it.
    localparam int ROB_TAG_W = 8;

    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;
    localparam int         SZ_SIGNED = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsb_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic [2:0]           size;
        logic [31:0]          rs1_val;
        logic [ROB_TAG_W-1:0] rs1_tag;
        logic                 rs1_rdy;
        logic [31:0]          rs2_val;
        logic [ROB_TAG_W-1:0] rs2_tag;
        logic                 rs2_rdy;
        logic [31:0]          imm;
        logic [ROB_TAG_W-1:0] rob_id;
    } lsb_entry_t;

    // Capture a CDB broadcast into any operand still waiting on that tag.
    function automatic lsb_entry_t lsb_snoop(
        input lsb_entry_t           e,
        input logic                 bus_valid,
        input logic [ROB_TAG_W-1:0] bus_tag,
        input logic [31:0]          bus_value
    );
        lsb_entry_t r;
        r = e;
        if (bus_valid && !e.rs1_rdy && (e.rs1_tag == bus_tag)) begin
            r.rs1_val = bus_value;
            r.rs1_rdy = 1'b1;
        end
        if (bus_valid && !e.rs2_rdy && (e.rs2_tag == bus_tag)) begin
            r.rs2_val = bus_value;
            r.rs2_rdy = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lsb_ptr_ctrl.sv
// Head/tail/count bookkeeping for the load/store buffer ring, including flush.
module lsb_ptr_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [PTR_W:0]   count,
    output logic             empty
);

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [PTR_W:0]   count_reg, count_next;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers are exactly PTR_W bits, so DEPTH being a power of two gives the wrap for free.
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push_ok) tail_next = tail_reg + PTR_W'(1);
            if (pop_ok)  head_next = head_reg + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + (PTR_W+1)'(1);
                2'b01:   count_next = count_reg - (PTR_W+1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (rdy_in) begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign head  = head_reg;
    assign tail  = tail_reg;
    assign count = count_reg;

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue issuing one request at a time to the cache.
// Optional performance counters are built when LSB_PERF_EN is defined.
module load_store_buffer #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             rob_clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_wr,
    input  logic [2:0]       in_size,
    input  logic [31:0]      in_rs1_val,
    input  logic [31:0]      in_rs2_val,
    input  logic [ROB_W-1:0] in_rs1_tag,
    input  logic [ROB_W-1:0] in_rs2_tag,
    input  logic             in_rs1_rdy,
    input  logic             in_rs2_rdy,
    input  logic [31:0]      in_imm,
    input  logic [ROB_W-1:0] in_rob_id,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic [ROB_W-1:0] rob_head_id,
    output logic             data_valid,
    output logic             data_wr,
    output logic [2:0]       data_size,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_value,
    input  logic             data_ready,
    input  logic [31:0]      data_res,
    output logic             out_valid,
    output logic [ROB_W-1:0] out_rob_id,
    output logic [31:0]      out_value,
    output logic             out_is_store
`ifdef LSB_PERF_EN
    ,
    output logic [31:0]      perf_loads,
    output logic [31:0]      perf_stores,
    output logic [31:0]      perf_stall_cycles
`endif
);

    import lsb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]     head, tail;
    logic [PTR_W:0]       count;
    logic                 q_empty;
    logic                 enq, deq;
    logic [ROB_TAG_W-1:0] cdb_tag_x, rob_head_x;
    lsb_entry_t           new_e, head_e;
    lsb_entry_t           entry_q [DEPTH];
    logic                 issuable;

    lsb_state_e           state_reg, state_next;
    logic                 data_valid_reg, data_valid_next;
    logic                 data_wr_reg, data_wr_next;
    logic [2:0]           data_size_reg, data_size_next;
    logic [31:0]          data_addr_reg, data_addr_next;
    logic [31:0]          data_value_reg, data_value_next;
    logic                 out_valid_reg, out_valid_next;
    logic [ROB_W-1:0]     out_rob_id_reg, out_rob_id_next;
    logic [31:0]          out_value_reg, out_value_next;
    logic                 out_is_store_reg, out_is_store_next;

    assign cdb_tag_x  = ROB_TAG_W'(cdb_tag);
    assign rob_head_x = ROB_TAG_W'(rob_head_id);
    assign in_ready   = (count != (PTR_W+1)'(DEPTH));
    assign enq        = in_valid && in_ready && !rob_clear;

    lsb_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (rob_clear),
        .push   (enq),
        .pop    (deq),
        .head   (head),
        .tail   (tail),
        .count  (count),
        .empty  (q_empty)
    );

    // Incoming entry already sees a same-cycle CDB broadcast for its operands.
    always_comb begin
        new_e         = '0;
        new_e.valid   = 1'b1;
        new_e.wr      = in_wr;
        new_e.size    = in_size;
        new_e.rs1_val = in_rs1_val;
        new_e.rs1_tag = ROB_TAG_W'(in_rs1_tag);
        new_e.rs1_rdy = in_rs1_rdy;
        new_e.rs2_val = in_rs2_val;
        new_e.rs2_tag = ROB_TAG_W'(in_rs2_tag);
        new_e.rs2_rdy = in_rs2_rdy;
        new_e.imm     = in_imm;
        new_e.rob_id  = ROB_TAG_W'(in_rob_id);
        new_e         = lsb_snoop(new_e, cdb_valid, cdb_tag_x, cdb_value);
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        lsb_entry_t ent_reg, ent_next;

        // Enqueue and dequeue never target the same slot: that needs count 0 or count DEPTH.
        always_comb begin
            ent_next = ent_reg;
            if (rob_clear) begin
                ent_next.valid = 1'b0;
            end else if (enq && (tail == PTR_W'(gi))) begin
                ent_next = new_e;
            end else if (deq && (head == PTR_W'(gi))) begin
                ent_next.valid = 1'b0;
            end else if (ent_reg.valid) begin
                ent_next = lsb_snoop(ent_reg, cdb_valid, cdb_tag_x, cdb_value);
            end
        end

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                ent_reg <= '0;
            end else if (rdy_in) begin
                ent_reg <= ent_next;
            end
        end

        assign entry_q[gi] = ent_reg;
    end

    assign head_e   = entry_q[head];
    assign issuable = !q_empty && head_e.valid && head_e.rs1_rdy &&
                      (!head_e.wr || (head_e.rs2_rdy && (head_e.rob_id == rob_head_x)));

    always_comb begin
        state_next        = state_reg;
        data_valid_next   = data_valid_reg;
        data_wr_next      = data_wr_reg;
        data_size_next    = data_size_reg;
        data_addr_next    = data_addr_reg;
        data_value_next   = data_value_reg;
        out_valid_next    = 1'b0;
        out_rob_id_next   = out_rob_id_reg;
        out_value_next    = out_value_reg;
        out_is_store_next = out_is_store_reg;
        deq               = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (issuable) begin
                    data_valid_next = 1'b1;
                    data_wr_next    = head_e.wr;
                    data_size_next  = head_e.size;
                    data_addr_next  = head_e.rs1_val + head_e.imm;
                    data_value_next = head_e.wr ? head_e.rs2_val : 32'd0;
                    state_next      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_ready) begin
                    data_valid_next   = 1'b0;
                    deq               = 1'b1;
                    out_valid_next    = 1'b1;
                    out_rob_id_next   = head_e.rob_id[ROB_W-1:0];
                    out_is_store_next = head_e.wr;
                    out_value_next    = head_e.wr ? 32'd0 : data_res;
                    state_next        = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // The cache flushes on the same signal, so an in-flight request is simply dropped.
        if (rob_clear) begin
            state_next      = ST_IDLE;
            data_valid_next = 1'b0;
            out_valid_next  = 1'b0;
            deq             = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg        <= ST_IDLE;
            data_valid_reg   <= 1'b0;
            data_wr_reg      <= 1'b0;
            data_size_reg    <= '0;
            data_addr_reg    <= '0;
            data_value_reg   <= '0;
            out_valid_reg    <= 1'b0;
            out_rob_id_reg   <= '0;
            out_value_reg    <= '0;
            out_is_store_reg <= 1'b0;
        end else if (rdy_in) begin
            state_reg        <= state_next;
            data_valid_reg   <= data_valid_next;
            data_wr_reg      <= data_wr_next;
            data_size_reg    <= data_size_next;
            data_addr_reg    <= data_addr_next;
            data_value_reg   <= data_value_next;
            out_valid_reg    <= out_valid_next;
            out_rob_id_reg   <= out_rob_id_next;
            out_value_reg    <= out_value_next;
            out_is_store_reg <= out_is_store_next;
        end
    end

    assign data_valid   = data_valid_reg;
    assign data_wr      = data_wr_reg;
    assign data_size    = data_size_reg;
    assign data_addr    = data_addr_reg;
    assign data_value   = data_value_reg;
    assign out_valid    = out_valid_reg;
    assign out_rob_id   = out_rob_id_reg;
    assign out_value    = out_value_reg;
    assign out_is_store = out_is_store_reg;

`ifdef LSB_PERF_EN
    logic [31:0] perf_loads_reg, perf_stores_reg, perf_stall_reg;

    // Counters survive rob_clear so they cover the whole run.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_loads_reg  <= '0;
            perf_stores_reg <= '0;
            perf_stall_reg  <= '0;
        end else if (rdy_in) begin
            if (deq && !head_e.wr) perf_loads_reg  <= perf_loads_reg + 32'd1;
            if (deq && head_e.wr)  perf_stores_reg <= perf_stores_reg + 32'd1;
            if ((state_reg == ST_IDLE) && !q_empty && head_e.valid && !issuable)
                perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_loads        = perf_loads_reg;
    assign perf_stores       = perf_stores_reg;
    assign perf_stall_cycles = perf_stall_reg;
`endif

endmodule

// File: tb/tb_load_store_buffer.sv
// Self-checking bench for load_store_buffer: vector table plus directed
// sequences, with request/completion scoreboards and a small cache model.
module tb_load_store_buffer;

    logic        clk_in, rst_in, rdy_in, rob_clear;
    logic        in_valid, in_ready, in_wr;
    logic [2:0]  in_size;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic [3:0]  in_rs1_tag, in_rs2_tag, in_rob_id;
    logic        in_rs1_rdy, in_rs2_rdy;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [3:0]  rob_head_id;
    logic        data_valid, data_wr;
    logic [2:0]  data_size;
    logic [31:0] data_addr, data_value;
    logic        data_ready;
    logic [31:0] data_res;
    logic        out_valid;
    logic [3:0]  out_rob_id;
    logic [31:0] out_value;
    logic        out_is_store;

    load_store_buffer #(.DEPTH(8), .ROB_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr), .in_size(in_size),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag),
        .in_rs1_rdy(in_rs1_rdy), .in_rs2_rdy(in_rs2_rdy),
        .in_imm(in_imm), .in_rob_id(in_rob_id),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .rob_head_id(rob_head_id),
        .data_valid(data_valid), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_value(data_value),
        .data_ready(data_ready), .data_res(data_res),
        .out_valid(out_valid), .out_rob_id(out_rob_id),
        .out_value(out_value), .out_is_store(out_is_store)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] rs2;
        logic [3:0]  rob;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct packed {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] value;
    } iss_t;

    typedef struct packed {
        logic [3:0]  rob;
        logic        st;
        logic [31:0] value;
    } comp_t;

    iss_t  exp_iss[$];
    comp_t exp_comp[$];
    vec_t  vecs[6];

    int n_checks = 0;
    int n_fail   = 0;
    int comp_seen = 0;
    int done_target = 0;

    logic cache_en  = 1'b0;
    int   cache_lat = 2;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    function automatic logic [31:0] cache_fn(input logic [31:0] addr);
        if (addr == 32'h0000_1004) return 32'hDEAD_BEEF;
        return {addr[15:0], ~addr[15:0]};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_op(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] rs2, input logic [3:0] rob);
        exp_iss.push_back('{wr, size, addr, wr ? rs2 : 32'd0});
        exp_comp.push_back('{rob, wr, wr ? 32'd0 : cache_fn(addr)});
    endtask

    task automatic enq(input logic wr, input logic [2:0] size, input logic [31:0] rs1,
                       input logic r1rdy, input logic [3:0] t1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [3:0] rob);
        int n;
        n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL enq_timeout: in_ready %b, expected 1", in_ready);
        end
        in_valid = 1'b1; in_wr = wr; in_size = size; in_rs1_val = rs1;
        in_rs1_rdy = r1rdy; in_rs1_tag = t1; in_rs2_val = rs2; in_imm = imm; in_rob_id = rob;
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        in_rs1_rdy = 1'b1;
        $display("enq wr=%0d rs1=%h imm=%h rob=%0d", wr, rs1, imm, rob);
    endtask

    task automatic wait_comp(input int target);
        int n;
        n = 0;
        while (comp_seen < target && n < 400) begin
            @(posedge clk_in); #1;
            n++;
        end
        check("completion_count", 96'(comp_seen), 96'(target));
    endtask

    task automatic wait_dv();
        int n;
        n = 0;
        while (!data_valid && n < 100) begin
            @(posedge clk_in); #1;
            n++;
        end
        check("wait_data_valid", 96'(data_valid), 96'd1);
    endtask

    // Cache model: answers each request after cache_lat cycles, holding data_ready until consumed.
    initial begin : cache_model
        logic busy;
        int   cnt;
        busy = 1'b0;
        cnt = 0;
        data_ready = 1'b0;
        data_res = 32'd0;
        forever begin
            @(posedge clk_in); #1;
            if (cache_en) begin
                if (!data_valid) begin
                    busy = 1'b0;
                    data_ready = 1'b0;
                end else if (!busy) begin
                    busy = 1'b1;
                    cnt = cache_lat;
                    data_ready = 1'b0;
                end else if (cnt > 0) begin
                    cnt--;
                end else begin
                    data_ready = 1'b1;
                    data_res = cache_fn(data_addr);
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Monitor: one line per request issued and per completion.
    logic  dv_prev = 1'b0, ov_prev = 1'b0;
    iss_t  ie;
    comp_t ce;
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (data_valid && !dv_prev) begin
                $display("issue wr=%0d size=%0d addr=%h value=%h", data_wr, data_size, data_addr, data_value);
                if (exp_iss.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_issue: addr %h, expected no request", data_addr);
                end else begin
                    ie = exp_iss.pop_front();
                    check("issue", 96'({data_wr, data_size, data_addr, data_value}), 96'(ie));
                end
            end
            if (out_valid) begin
                $display("complete rob=%0d store=%0d value=%h", out_rob_id, out_is_store, out_value);
                check("out_pulse_len", 96'(ov_prev), 96'd0);
                if (exp_comp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: rob %0d, expected none", out_rob_id);
                end else begin
                    ce = exp_comp.pop_front();
                    check("complete", 96'({out_rob_id, out_is_store, out_value}), 96'(ce));
                end
                comp_seen++;
            end
        end
        dv_prev = data_valid;
        ov_prev = out_valid;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vecs[0] = '{1'b0, 3'd2, 32'h0000_1000, 32'h0000_0004, 32'h0000_5555, 4'd1,  32'h0000_1004};
        vecs[1] = '{1'b1, 3'd2, 32'h0000_2000, 32'hFFFF_FFFC, 32'hCAFE_F00D, 4'd2,  32'h0000_1FFC};
        vecs[2] = '{1'b0, 3'd4, 32'h0000_0300, 32'h0000_0021, 32'h0000_7777, 4'd3,  32'h0000_0321};
        vecs[3] = '{1'b1, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h0000_1234, 4'd4,  32'h0000_0000};
        vecs[4] = '{1'b0, 3'd5, 32'h7FFF_FFF0, 32'h0000_0010, 32'h0000_0001, 4'd5,  32'h8000_0000};
        vecs[5] = '{1'b1, 3'd0, 32'h0000_0044, 32'h0000_0000, 32'h0000_00FF, 4'd15, 32'h0000_0044};

        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0;
        in_valid = 1'b0; in_wr = 1'b0; in_size = 3'd0;
        in_rs1_val = 32'd0; in_rs2_val = 32'd0; in_imm = 32'd0;
        in_rs1_tag = 4'd0; in_rs2_tag = 4'd0; in_rob_id = 4'd0;
        in_rs1_rdy = 1'b1; in_rs2_rdy = 1'b1;
        cdb_valid = 1'b0; cdb_tag = 4'd0; cdb_value = 32'd0;
        rob_head_id = 4'd0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        check("reset_ctrl", 96'({data_valid, data_wr, data_size, out_valid, out_is_store, out_rob_id}), 96'd0);
        check("reset_data", 96'({data_addr, data_value, out_value}), 96'd0);
        check("reset_in_ready", 96'(in_ready), 96'd1);

        // Vector table: one access at a time, issue latency and contents checked.
        cache_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rob_head_id = vecs[i].rob;
            expect_op(vecs[i].wr, vecs[i].size, vecs[i].exp_addr, vecs[i].rs2, vecs[i].rob);
            enq(vecs[i].wr, vecs[i].size, vecs[i].rs1, 1'b1, 4'd0, vecs[i].rs2, vecs[i].imm, vecs[i].rob);
            @(posedge clk_in); #1;
            check("issue_latency", 96'(data_valid), 96'd1);
            done_target++;
            wait_comp(done_target);
        end

        // Store waits until it is the ROB head.
        rob_head_id = 4'd2;
        expect_op(1'b1, 3'd2, 32'h0000_0620, 32'h1122_3344, 4'd3);
        enq(1'b1, 3'd2, 32'h0000_0600, 1'b1, 4'd0, 32'h1122_3344, 32'h0000_0020, 4'd3);
        repeat (5) @(posedge clk_in);
        #1;
        check("store_blocked", 96'(data_valid), 96'd0);
        rob_head_id = 4'd3;
        @(posedge clk_in); #1;
        check("store_issue_latency", 96'(data_valid), 96'd1);
        done_target++;
        wait_comp(done_target);

        // CDB wakes rs1 on the enqueue cycle.
        expect_op(1'b0, 3'd2, 32'h0000_0030, 32'd0, 4'd6);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_value = 32'h0000_0020;
        enq(1'b0, 3'd2, 32'h0000_DEAD, 1'b0, 4'd5, 32'd0, 32'h0000_0010, 4'd6);
        cdb_valid = 1'b0;
        done_target++;
        wait_comp(done_target);

        // CDB wakes rs1 later; a wrong-tag broadcast must not.
        expect_op(1'b0, 3'd2, 32'h0000_0028, 32'd0, 4'd7);
        enq(1'b0, 3'd2, 32'h0000_BEEF, 1'b0, 4'd6, 32'd0, 32'h0000_0008, 4'd7);
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 32'h0000_0999;
        @(posedge clk_in); #1;
        cdb_valid = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("cdb_not_ready", 96'(data_valid), 96'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'h0000_0020;
        @(posedge clk_in); #1;
        cdb_valid = 1'b0;
        done_target++;
        wait_comp(done_target);

        // Fill the queue, then drain across the pointer wrap.
        cache_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            expect_op(1'b0, 3'd2, (32'(k) << 8) + 32'(k), 32'd0, 4'(k));
            enq(1'b0, 3'd2, 32'(k) << 8, 1'b1, 4'd0, 32'd0, 32'(k), 4'(k));
        end
        check("full_in_ready", 96'(in_ready), 96'd0);
        in_valid = 1'b1; in_wr = 1'b0; in_rs1_val = 32'h0000_BAD0; in_imm = 32'd0; in_rob_id = 4'd9;
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        check("full_still_blocked", 96'(in_ready), 96'd0);
        cache_en = 1'b1;
        wait_comp(done_target + 3);
        for (int k = 8; k < 11; k++) begin
            expect_op(1'b0, 3'd2, (32'(k) << 8) + 32'(k), 32'd0, 4'(k));
            enq(1'b0, 3'd2, 32'(k) << 8, 1'b1, 4'd0, 32'd0, 32'(k), 4'(k));
        end
        done_target += 11;
        wait_comp(done_target);
        check("drained_in_ready", 96'(in_ready), 96'd1);

        // Flush while a request is outstanding; an enqueue in the flush cycle is dropped.
        cache_en = 1'b0;
        expect_op(1'b0, 3'd2, 32'h0000_0500, 32'd0, 4'd1);
        enq(1'b0, 3'd2, 32'h0000_0500, 1'b1, 4'd0, 32'd0, 32'd0, 4'd1);
        wait_dv();
        void'(exp_comp.pop_back());
        rob_clear = 1'b1;
        in_valid = 1'b1; in_wr = 1'b0; in_rs1_val = 32'h0000_0BAD; in_imm = 32'd0; in_rob_id = 4'd2;
        @(posedge clk_in); #1;
        rob_clear = 1'b0;
        in_valid = 1'b0;
        check("flush_data_valid", 96'(data_valid), 96'd0);
        check("flush_in_ready", 96'(in_ready), 96'd1);
        repeat (4) @(posedge clk_in);
        #1;
        check("flush_quiet", 96'({data_valid, out_valid}), 96'd0);
        cache_en = 1'b1;
        expect_op(1'b0, 3'd2, 32'h0000_0700, 32'd0, 4'd4);
        enq(1'b0, 3'd2, 32'h0000_0700, 1'b1, 4'd0, 32'd0, 32'd0, 4'd4);
        done_target++;
        wait_comp(done_target);

        // Address wrap, then rdy_in low across the data_ready cycle.
        cache_en = 1'b0;
        expect_op(1'b0, 3'd2, 32'h0000_0004, 32'd0, 4'd8);
        enq(1'b0, 3'd2, 32'hFFFF_FFFC, 1'b1, 4'd0, 32'd0, 32'h0000_0008, 4'd8);
        wait_dv();
        data_ready = 1'b1;
        data_res = cache_fn(32'h0000_0004);
        rdy_in = 1'b0;
        for (int p = 0; p < 3; p++) begin
            @(posedge clk_in); #1;
            check("pause_hold", 96'({data_valid, out_valid, data_addr}), 96'({1'b1, 1'b0, 32'h0000_0004}));
        end
        rdy_in = 1'b1;
        @(posedge clk_in); #1;
        data_ready = 1'b0;
        check("pause_release", 96'({data_valid, out_valid}), 96'({1'b0, 1'b1}));
        done_target++;
        wait_comp(done_target);
        cache_en = 1'b1;

        repeat (3) @(posedge clk_in);
        #1;
        check("scoreboard_empty", 96'(exp_iss.size() + exp_comp.size()), 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
